// File: rtl/avalon_copy_master.sv
// Avalon-MM block-copy master: programmed through a 4-register slave port, then copies
// LEN 32-bit words from SRC to DST as one read and one write per word, with a done interrupt.
module avalon_copy_master #(
    parameter int unsigned ADDR_SEL_BITS = 0,
    parameter int unsigned ADDR_BLOCK    = 0
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_n,
    input  logic                      i_SlaveSel,
    input  logic [29-ADDR_SEL_BITS:0] i_RegAddr,
    input  logic [3:0]                i_AV_ByteEn,
    input  logic                      i_AV_Read,
    input  logic                      i_AV_Write,
    output logic [31:0]               o_AV_ReadData,
    input  logic [31:0]               i_AV_WriteData,
    output logic                      o_AV_WaitRequest,
    output logic [31:0]               o_M_Address,
    output logic [3:0]                o_M_ByteEn,
    output logic                      o_M_Read,
    output logic                      o_M_Write,
    output logic [31:0]               o_M_WriteData,
    input  logic [31:0]               i_M_ReadData,
    input  logic                      i_M_WaitRequest,
    output logic                      o_Irq
);

    localparam int unsigned RegAddrW = 30 - ADDR_SEL_BITS;

    typedef enum logic [1:0] {StIdle, StRd, StRdata, StWr} state_e;

    state_e      state;
    logic [31:0] src_reg;
    logic [31:0] dst_reg;
    logic [31:0] len_reg;
    logic [31:0] cur_src;
    logic [31:0] cur_dst;
    logic [31:0] remaining;
    logic        irq_en;
    logic        done;

    logic        busy;
    logic        reg_wr;
    logic        reg_rd;
    logic        ctrl_wr;
    logic        launch;
    logic        clear_done;
    logic [31:0] read_mux;
    logic        unused_block;

    assign unused_block     = ADDR_BLOCK[0];
    assign o_AV_WaitRequest = 1'b0;
    assign o_Irq            = done & irq_en;

    assign busy       = (state != StIdle);
    assign reg_wr     = i_SlaveSel & i_AV_Write;
    assign reg_rd     = i_SlaveSel & i_AV_Read;
    assign ctrl_wr    = reg_wr & (i_RegAddr == RegAddrW'(0)) & i_AV_ByteEn[0];
    assign launch     = ctrl_wr & i_AV_WriteData[0] & ~busy;
    assign clear_done = ctrl_wr & i_AV_WriteData[2];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        read_mux = 32'h0;
        if (i_RegAddr == RegAddrW'(0)) begin
            read_mux = {28'h0, irq_en, done, busy, 1'b0};
        end else if (i_RegAddr == RegAddrW'(1)) begin
            read_mux = src_reg;
        end else if (i_RegAddr == RegAddrW'(2)) begin
            read_mux = dst_reg;
        end else if (i_RegAddr == RegAddrW'(3)) begin
            read_mux = len_reg;
        end
    end

    // Slave register file; SRC/DST/LEN are frozen while a copy is in flight.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            src_reg       <= 32'h0;
            dst_reg       <= 32'h0;
            len_reg       <= 32'h0;
            irq_en        <= 1'b0;
            o_AV_ReadData <= 32'h0;
        end else begin
            if (ctrl_wr) begin
                irq_en <= i_AV_WriteData[3];
            end
            if (reg_wr && !busy) begin
                if (i_RegAddr == RegAddrW'(1)) begin
                    src_reg <= merge_bytes(src_reg, i_AV_WriteData, i_AV_ByteEn) & 32'hFFFF_FFFC;
                end else if (i_RegAddr == RegAddrW'(2)) begin
                    dst_reg <= merge_bytes(dst_reg, i_AV_WriteData, i_AV_ByteEn) & 32'hFFFF_FFFC;
                end else if (i_RegAddr == RegAddrW'(3)) begin
                    len_reg <= merge_bytes(len_reg, i_AV_WriteData, i_AV_ByteEn);
                end
            end
            o_AV_ReadData <= reg_rd ? read_mux : 32'h0;
        end
    end

    // Copy engine. o_M_WriteData doubles as the captured read-data register.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state         <= StIdle;
            cur_src       <= 32'h0;
            cur_dst       <= 32'h0;
            remaining     <= 32'h0;
            done          <= 1'b0;
            o_M_Address   <= 32'h0;
            o_M_ByteEn    <= 4'h0;
            o_M_Read      <= 1'b0;
            o_M_Write     <= 1'b0;
            o_M_WriteData <= 32'h0;
        end else begin
            if (clear_done) begin
                done <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (launch) begin
                        cur_src   <= src_reg;
                        cur_dst   <= dst_reg;
                        remaining <= len_reg;
                        if (len_reg == 32'h0) begin
                            done <= 1'b1;
                        end else begin
                            done        <= 1'b0;
                            state       <= StRd;
                            o_M_Read    <= 1'b1;
                            o_M_ByteEn  <= 4'hF;
                            o_M_Address <= src_reg;
                        end
                    end
                end
                StRd: begin
                    if (!i_M_WaitRequest) begin
                        state       <= StRdata;
                        o_M_Read    <= 1'b0;
                        o_M_ByteEn  <= 4'h0;
                        o_M_Address <= 32'h0;
                    end
                end
                StRdata: begin
                    state         <= StWr;
                    o_M_Write     <= 1'b1;
                    o_M_ByteEn    <= 4'hF;
                    o_M_Address   <= cur_dst;
                    o_M_WriteData <= i_M_ReadData;
                end
                StWr: begin
                    if (!i_M_WaitRequest) begin
                        cur_src       <= cur_src + 32'd4;
                        cur_dst       <= cur_dst + 32'd4;
                        remaining     <= remaining - 32'd1;
                        o_M_Write     <= 1'b0;
                        o_M_WriteData <= 32'h0;
                        if (remaining == 32'd1) begin
                            state       <= StIdle;
                            done        <= 1'b1;
                            o_M_ByteEn  <= 4'h0;
                            o_M_Address <= 32'h0;
                        end else begin
                            state       <= StRd;
                            o_M_Read    <= 1'b1;
                            o_M_Address <= cur_src + 32'd4;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
